// File: rtl/sa_pkg.sv
// Shared definitions for the weight-stationary systolic array front end:
// default geometry and the feeder controller state encoding.
package sa_pkg;

    localparam int SA_N          = 4;
    localparam int SA_DATA_WIDTH = 16;
    localparam int SA_LEN_WIDTH  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_W,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } feeder_state_e;

    // Counter width able to index 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ws_array_feeder_if.sv
// Weight-row and activation-vector valid/ready streams into the feeder.
interface ws_array_feeder_if #(
    parameter int N          = sa_pkg::SA_N,
    parameter int DATA_WIDTH = sa_pkg::SA_DATA_WIDTH
) ();

    logic                  w_valid;
    logic                  w_ready;
    logic [N*DATA_WIDTH-1:0] w_data;
    logic                  a_valid;
    logic                  a_ready;
    logic [N*DATA_WIDTH-1:0] a_data;

    modport master (
        output w_valid, w_data, a_valid, a_data,
        input  w_ready, a_ready
    );

    modport slave (
        input  w_valid, w_data, a_valid, a_data,
        output w_ready, a_ready
    );

endinterface

// File: rtl/skew_line.sv
// Fixed-depth delay chain for one array row, carrying {acc_en, data};
// asynchronous clear so a reset flushes all in-flight beats.
module skew_line #(
    parameter int DEPTH      = 1,
    parameter int DATA_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         in_en,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    output logic                         out_en,
    output logic signed [DATA_WIDTH-1:0] out_data
);

    logic                         en_p   [DEPTH];
    logic signed [DATA_WIDTH-1:0] data_p [DEPTH];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                en_p[i]   <= 1'b0;
                data_p[i] <= '0;
            end
        end else begin
            en_p[0]   <= in_en;
            data_p[0] <= in_data;
            for (int i = 1; i < DEPTH; i++) begin
                en_p[i]   <= en_p[i-1];
                data_p[i] <= data_p[i-1];
            end
        end
    end

    assign out_en   = en_p[DEPTH-1];
    assign out_data = data_p[DEPTH-1];

endmodule

// File: rtl/ws_array_feeder.sv
// Tile sequencer for a weight-stationary N x N array: loads N weight rows,
// streams vec_len activation vectors through per-row skew lines, then drains.
module ws_array_feeder
    import sa_pkg::*;
#(
    parameter int N          = SA_N,
    parameter int DATA_WIDTH = SA_DATA_WIDTH,
    parameter int LEN_WIDTH  = SA_LEN_WIDTH
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic [LEN_WIDTH-1:0]    vec_len,
    ws_array_feeder_if.slave        bus,
    output logic [N*DATA_WIDTH-1:0] weight_o,
    output logic [N-1:0]            load_en_o,
    output logic [N*DATA_WIDTH-1:0] data_o,
    output logic [N-1:0]            acc_en_o,
    output logic                    busy,
    output logic                    done
);

    localparam int CW = cnt_width(N);

    feeder_state_e        state, state_nxt;
    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH-1:0] vec_cnt;
    logic [CW-1:0]        w_cnt;
    logic [CW-1:0]        d_cnt;
    logic                 w_hs, a_hs;
    logic                 w_last, a_last, d_last;

    // Handshakes decoded from state directly to keep ready out of the next-state loop.
    assign w_hs   = bus.w_valid & (state == ST_LOAD_W);
    assign a_hs   = bus.a_valid & (state == ST_STREAM);
    assign w_last = (w_cnt == CW'(N-1));
    assign a_last = (vec_cnt == len_q - 1'b1);
    assign d_last = (d_cnt == CW'(N-1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        bus.w_ready = 1'b0;
        bus.a_ready = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = ST_LOAD_W;
            end
            ST_LOAD_W: begin
                bus.w_ready = 1'b1;
                if (w_hs && w_last) state_nxt = (len_q != '0) ? ST_STREAM : ST_DONE;
            end
            ST_STREAM: begin
                bus.a_ready = 1'b1;
                if (a_hs && a_last) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (d_last) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            len_q   <= '0;
            vec_cnt <= '0;
            w_cnt   <= '0;
            d_cnt   <= '0;
        end else begin
            if (state == ST_IDLE && start) len_q <= vec_len;
            if (state == ST_IDLE)  vec_cnt <= '0;
            else if (a_hs)         vec_cnt <= vec_cnt + 1'b1;
            if (state == ST_IDLE)  w_cnt <= '0;
            else if (w_hs)         w_cnt <= w_cnt + 1'b1;
            if (state == ST_DRAIN) d_cnt <= d_cnt + 1'b1;
            else                   d_cnt <= '0;
        end
    end

    // Weight broadcast holds its value between strobes.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            weight_o  <= '0;
            load_en_o <= '0;
        end else begin
            load_en_o <= w_hs ? (N'(1) << w_cnt) : '0;
            if (w_hs) weight_o <= bus.w_data;
        end
    end

    // Non-handshake cycles enter the skew lines as zero bubbles.
    for (genvar r = 0; r < N; r++) begin : g_row
        logic signed [DATA_WIDTH-1:0] lane_in;
        logic signed [DATA_WIDTH-1:0] lane_out;
        logic                         en_out;

        assign lane_in = a_hs ? $signed(bus.a_data[r*DATA_WIDTH +: DATA_WIDTH]) : '0;

        skew_line #(
            .DEPTH      (r + 1),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_skew (
            .clk      (clk),
            .rstn     (rstn),
            .in_en    (a_hs),
            .in_data  (lane_in),
            .out_en   (en_out),
            .out_data (lane_out)
        );

        assign data_o[r*DATA_WIDTH +: DATA_WIDTH] = lane_out;
        assign acc_en_o[r]                         = en_out;
    end

endmodule

// File: tb/tb_ws_array_feeder.sv
// Scoreboard bench for ws_array_feeder: drivers push expected strobes with
// their cycle numbers, a negedge monitor pops and compares them.
module tb_ws_array_feeder;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int LW = 8;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            start = 1'b0;
    logic [LW-1:0]   vec_len = '0;
    logic [N*DW-1:0] weight_o, data_o;
    logic [N-1:0]    load_en_o, acc_en_o;
    logic            busy, done;

    ws_array_feeder_if #(.N(N), .DATA_WIDTH(DW)) bus ();

    ws_array_feeder #(.N(N), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .vec_len   (vec_len),
        .bus       (bus),
        .weight_o  (weight_o),
        .load_en_o (load_en_o),
        .data_o    (data_o),
        .acc_en_o  (acc_en_o),
        .busy      (busy),
        .done      (done)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic [N-1:0] oh; logic [N*DW-1:0] data; } wexp_t;
    typedef struct { int cyc; logic [DW-1:0] val; } dexp_t;

    wexp_t           wq[$];
    dexp_t           dq[N][$];
    int              dnq[$];
    logic [N*DW-1:0] last_w = '0;
    int              n_chk = 0;
    int              n_fail = 0;
    int              wk = 0;
    int              cur_len = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        n_chk++;
        n_fail++;
        $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
    endtask

    function automatic logic [N*DW-1:0] mk(input int base, input int step);
        logic [N*DW-1:0] v;
        for (int c = 0; c < N; c++) v[c*DW +: DW] = DW'(base + step * c);
        return v;
    endfunction

    // Monitor / scoreboard
    initial begin
        wexp_t we;
        dexp_t de;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                last_w = '0;
            end else begin
                if (load_en_o != '0) begin
                    if (wq.size() == 0) begin
                        fail_now("load_en", $sformatf("got %b expected no strobe", load_en_o));
                    end else begin
                        we = wq.pop_front();
                        check_int("load_en cycle", cyc, we.cyc);
                        check("load_en", 64'(load_en_o), 64'(we.oh));
                        check("weight_o", 64'(weight_o), 64'(we.data));
                        last_w = we.data;
                    end
                end else begin
                    check("weight hold", 64'(weight_o), 64'(last_w));
                end
                for (int r = 0; r < N; r++) begin
                    if (acc_en_o[r]) begin
                        if (dq[r].size() == 0) begin
                            fail_now($sformatf("row%0d acc_en", r), "got 1 expected 0");
                        end else begin
                            de = dq[r].pop_front();
                            check_int($sformatf("row%0d cycle", r), cyc, de.cyc);
                            check($sformatf("row%0d data", r), 64'(data_o[r*DW +: DW]), 64'(de.val));
                        end
                    end else begin
                        check($sformatf("row%0d bubble", r), 64'(data_o[r*DW +: DW]), 64'(0));
                    end
                end
                if (done) begin
                    if (dnq.size() == 0) fail_now("done", "got 1 expected 0");
                    else check_int("done cycle", cyc, dnq.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        check({tag, " weight_o"}, 64'(weight_o), 64'(0));
        check({tag, " data_o"}, 64'(data_o), 64'(0));
        check({tag, " load_en_o"}, 64'(load_en_o), 64'(0));
        check({tag, " acc_en_o"}, 64'(acc_en_o), 64'(0));
        check({tag, " busy"}, 64'(busy), 64'(0));
        check({tag, " done"}, 64'(done), 64'(0));
        check({tag, " w_ready"}, 64'(bus.w_ready), 64'(0));
        check({tag, " a_ready"}, 64'(bus.a_ready), 64'(0));
    endtask

    task automatic start_tile(input int len);
        check("idle busy", 64'(busy), 64'(0));
        check("idle w_ready", 64'(bus.w_ready), 64'(0));
        start   = 1'b1;
        vec_len = LW'(len);
        tick();
        start   = 1'b0;
        vec_len = '0;
        wk      = 0;
        cur_len = len;
        check("busy after start", 64'(busy), 64'(1));
        check("w_ready in LOAD_W", 64'(bus.w_ready), 64'(1));
        check("a_ready in LOAD_W", 64'(bus.a_ready), 64'(0));
    endtask

    task automatic send_w(input logic [N*DW-1:0] d);
        bit ok = 1'b0;
        bus.w_valid = 1'b1;
        bus.w_data  = d;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (bus.w_ready) begin
                ok = 1'b1;
                wq.push_back('{cyc + 1, N'(1) << wk, d});
                if (wk == N - 1 && cur_len == 0) dnq.push_back(cyc + 1);
                wk++;
            end
            tick();
        end
        bus.w_valid = 1'b0;
        if (!ok) fail_now("w handshake", "got w_ready=0 for 50 cycles expected 1");
    endtask

    task automatic load_weights(input int seed);
        for (int k = 0; k < N; k++) send_w(mk(k + 1 + seed, 16));
        check("w_ready after loads", 64'(bus.w_ready), 64'(0));
        check("a_ready after loads", 64'(bus.a_ready), 64'(cur_len > 0));
    endtask

    task automatic send_a(input logic [N*DW-1:0] d, input bit last);
        bit ok = 1'b0;
        bus.a_valid = 1'b1;
        bus.a_data  = d;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (bus.a_ready) begin
                ok = 1'b1;
                for (int r = 0; r < N; r++) dq[r].push_back('{cyc + 1 + r, d[r*DW +: DW]});
                if (last) dnq.push_back(cyc + N + 1);
            end
            tick();
        end
        bus.a_valid = 1'b0;
        if (!ok) fail_now("a handshake", "got a_ready=0 for 50 cycles expected 1");
        if (last) check("a_ready drop", 64'(bus.a_ready), 64'(0));
    endtask

    task automatic wait_done();
        for (int i = 0; i < 50 && dnq.size() != 0; i++) @(negedge clk);
        if (dnq.size() != 0) fail_now("done wait", "got no done within 50 cycles expected pulse");
        tick();
        check("busy after done", 64'(busy), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.w_valid = 1'b0;
        bus.w_data  = '0;
        bus.a_valid = 1'b0;
        bus.a_data  = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        tick();
        rstn = 1'b1;
        @(negedge clk);
        chk_zero("post reset");
        tick();

        // Three vectors back to back
        start_tile(3);
        load_weights(0);
        for (int j = 0; j < 3; j++) send_a(mk(10 + j, 10), j == 2);
        wait_done();

        // Two vectors with a two-cycle valid gap, including negative lanes
        start_tile(2);
        load_weights(1);
        send_a(mk(-100, -7), 1'b0);
        repeat (2) tick();
        send_a(mk(300, 1), 1'b1);
        wait_done();

        // Zero-length tile: weights only
        start_tile(0);
        load_weights(2);
        wait_done();

        // Reset mid-stream aborts the tile
        start_tile(3);
        load_weights(3);
        send_a(mk(5, 1), 1'b0);
        rstn = 1'b0;
        wq.delete();
        dnq.delete();
        for (int r = 0; r < N; r++) dq[r].delete();
        #1;
        chk_zero("async reset");
        tick();
        rstn = 1'b1;
        @(negedge clk);
        chk_zero("after abort");
        tick();
        start_tile(1);
        load_weights(4);
        send_a(mk(77, -2), 1'b1);
        wait_done();

        // Start during STREAM must not relatch vec_len
        start_tile(2);
        load_weights(5);
        send_a(mk(1, 2), 1'b0);
        start   = 1'b1;
        vec_len = LW'(5);
        tick();
        start   = 1'b0;
        vec_len = '0;
        check("busy in STREAM", 64'(busy), 64'(1));
        send_a(mk(-3, -4), 1'b1);
        wait_done();

        // Maximum vector count
        start_tile(255);
        load_weights(6);
        for (int j = 0; j < 255; j++) send_a(mk(j, 3), j == 254);
        wait_done();

        repeat (10) tick();
        check_int("leftover weight expectations", wq.size(), 0);
        check_int("leftover done expectations", dnq.size(), 0);
        for (int r = 0; r < N; r++) check_int($sformatf("leftover row%0d expectations", r), dq[r].size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
